// File: rtl/mips_pkg.sv
// Purpose: shared types and encodings for the multicycle MIPS controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

  localparam int ALU_CTRL_WIDTH = 4;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    IMM_EX   = 4'd8,
    IMM_WB   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  // opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // funct codes (instr[5:0]) for R-type
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;

  // ALU operation encodings
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_XOR  = 4'b0011;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_NOR  = 4'b0100;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB  = 4'b0110;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT  = 4'b0111;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLL  = 4'b1000;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRL  = 4'b1001;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRA  = 4'b1010;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLLV = 4'b1011;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRLV = 4'b1100;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRAV = 4'b1101;

endpackage

// File: rtl/alu_decoder.sv
// Purpose: opcode/funct to alu_control decode, plus instruction legality.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
// Ports: opcode/funct in; alu_control out (ADD when not an ALU op); legal=0 for
//        unknown opcodes and for R-type with an unknown funct.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0]                opcode,
  input  logic [5:0]                funct,
  output logic [ALU_CTRL_WIDTH-1:0] alu_control,
  output logic                      legal
);

  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_XOR:  alu_control = ALU_XOR;
          FN_NOR:  alu_control = ALU_NOR;
          FN_SLT:  alu_control = ALU_SLT;
          FN_SLL:  alu_control = ALU_SLL;
          FN_SRL:  alu_control = ALU_SRL;
          FN_SRA:  alu_control = ALU_SRA;
          FN_SLLV: alu_control = ALU_SLLV;
          FN_SRLV: alu_control = ALU_SRLV;
          FN_SRAV: alu_control = ALU_SRAV;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: alu_control = ALU_ADD;
      OP_ANDI: alu_control = ALU_AND;
      OP_ORI:  alu_control = ALU_OR;
      OP_XORI: alu_control = ALU_XOR;
      OP_SLTI: alu_control = ALU_SLT;
      // non-ALU-class opcodes are legal; their ALU op is set by the FSM state
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: alu_control = ALU_ADD;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: multicycle MIPS control FSM (fetch/decode/execute/memory/writeback).
// Latency: outputs combinational from state_q + inputs; lw 5, sw/R/imm 4, br/j 3 cycles.
// Backpressure: mem_ready=0 stalls FETCH, MEMRD and MEMWR with the request held.
// Ports: clk, rst (sync, active-high); opcode/funct from the IR; zero_flag from
//        the ALU; mem_ready from memory; datapath enables/selects out;
//        illegal_instr pulses in DECODE on an unsupported opcode or funct.
module multicycle_ctrl
  import mips_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [5:0]                opcode,
  input  logic [5:0]                funct,
  input  logic                      zero_flag,
  input  logic                      mem_ready,
  output logic                      pc_en,
  output logic [1:0]                pc_src,
  output logic                      iord,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic                      ir_write,
  output logic                      reg_dst,
  output logic                      mem_to_reg,
  output logic                      reg_write,
  output logic                      alu_src_a,
  output logic [1:0]                alu_src_b,
  output logic [ALU_CTRL_WIDTH-1:0] alu_control,
  output logic                      illegal_instr
);

  state_t                    state_q, state_d;
  logic [ALU_CTRL_WIDTH-1:0] dec_alu;
  logic                      dec_legal;

  alu_decoder u_alu_decoder (
    .opcode      (opcode),
    .funct       (funct),
    .alu_control (dec_alu),
    .legal       (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_en         = 1'b0;
    pc_src        = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_control   = ALU_ADD;
    illegal_instr = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        // precompute branch target into ALU-out while the opcode is decoded
        alu_src_b = 2'b11;
        if (!dec_legal) begin
          illegal_instr = 1'b1;
          state_d       = FETCH;
        end else begin
          case (opcode)
            OP_LW, OP_SW:                                  state_d = MEMADR;
            OP_RTYPE:                                      state_d = RTYPE_EX;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI:    state_d = IMM_EX;
            OP_BEQ, OP_BNE:                                state_d = BRANCH;
            OP_J:                                          state_d = JUMP;
            default: begin
              illegal_instr = 1'b1;
              state_d       = FETCH;
            end
          endcase
        end
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      RTYPE_EX: begin
        alu_src_a   = 1'b1;
        alu_control = dec_alu;
        state_d     = RTYPE_WB;
      end
      RTYPE_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = FETCH;
      end
      IMM_EX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = dec_alu;
        state_d     = IMM_WB;
      end
      IMM_WB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_en       = (opcode == OP_BEQ) ? zero_flag :
                      (opcode == OP_BNE) ? ~zero_flag : 1'b0;
        state_d     = FETCH;
      end
      JUMP: begin
        pc_en   = 1'b1;
        pc_src  = 2'b10;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // outputs follow state_q, which only clears on the edge; mask side
    // effects for the whole time reset is held
    if (rst) begin
      pc_en         = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero_flag, mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, illegal_instr;
  logic [1:0] pc_src, alu_src_b;
  logic [ALU_CTRL_WIDTH-1:0] alu_control;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .zero_flag(zero_flag), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_src(pc_src), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic       illegal;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       zf;
    logic       rdy;
    out_t       exp;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];

  function automatic out_t o(input logic pe, input logic [1:0] ps, input logic io,
                             input logic mr, input logic mw, input logic irw,
                             input logic rd, input logic m2r, input logic rw,
                             input logic sa, input logic [1:0] sb,
                             input logic [3:0] alu, input logic ill);
    out_t r;
    r = {pe, ps, io, mr, mw, irw, rd, m2r, rw, sa, sb, alu, ill};
    return r;
  endfunction

  function automatic vec_t v(input logic r, input logic [5:0] op, input logic [5:0] fn,
                             input logic zf, input logic rdy, input out_t e);
    vec_t x;
    x.rst = r; x.op = op; x.fn = fn; x.zf = zf; x.rdy = rdy; x.exp = e;
    return x;
  endfunction

  // Called just after a falling edge: drive, settle, compare, then wait a cycle.
  task automatic apply(input vec_t x, input string name);
    out_t act;
    rst = x.rst; opcode = x.op; funct = x.fn; zero_flag = x.zf; mem_ready = x.rdy;
    #2;
    act = {pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_control, illegal_instr};
    checks++;
    if (act !== x.exp) begin
      errors++;
      $display("FAIL %s: got %b required %b (pe ps io mr mw irw rd m2r rw sa sb alu ill)",
               name, act, x.exp);
    end
    @(negedge clk);
  endtask

  out_t e_rst, e_fwait, e_fgo, e_dec, e_memadr, e_memrd, e_memwb, e_memwr;
  out_t e_rwb, e_iwb, e_jump;

  initial begin
    e_rst    = o(0,2'b00,0,0,0,0,0,0,0,0,2'b01,4'b0010,0);
    e_fwait  = o(0,2'b00,0,1,0,0,0,0,0,0,2'b01,4'b0010,0);
    e_fgo    = o(1,2'b00,0,1,0,1,0,0,0,0,2'b01,4'b0010,0);
    e_dec    = o(0,2'b00,0,0,0,0,0,0,0,0,2'b11,4'b0010,0);
    e_memadr = o(0,2'b00,0,0,0,0,0,0,0,1,2'b10,4'b0010,0);
    e_memrd  = o(0,2'b00,1,1,0,0,0,0,0,0,2'b00,4'b0010,0);
    e_memwb  = o(0,2'b00,0,0,0,0,0,1,1,0,2'b00,4'b0010,0);
    e_memwr  = o(0,2'b00,1,0,1,0,0,0,0,0,2'b00,4'b0010,0);
    e_rwb    = o(0,2'b00,0,0,0,0,1,0,1,0,2'b00,4'b0010,0);
    e_iwb    = o(0,2'b00,0,0,0,0,0,0,1,0,2'b00,4'b0010,0);
    e_jump   = o(1,2'b10,0,0,0,0,0,0,0,0,2'b00,4'b0010,0);

    // reset state, then lw with memory always ready: 5 cycles, write-back last
    tbl.push_back(v(1, 6'b100011, 6'd0, 0, 1, e_rst));
    tbl.push_back(v(0, 6'b100011, 6'd0, 0, 1, e_fgo));
    tbl.push_back(v(0, 6'b100011, 6'd0, 0, 1, e_dec));
    tbl.push_back(v(0, 6'b100011, 6'd0, 0, 1, e_memadr));
    tbl.push_back(v(0, 6'b100011, 6'd0, 0, 1, e_memrd));
    tbl.push_back(v(0, 6'b100011, 6'd0, 0, 1, e_memwb));
    // srav
    tbl.push_back(v(0, 6'b000000, 6'b000111, 0, 1, e_fgo));
    tbl.push_back(v(0, 6'b000000, 6'b000111, 0, 1, e_dec));
    tbl.push_back(v(0, 6'b000000, 6'b000111, 0, 1, o(0,2'b00,0,0,0,0,0,0,0,1,2'b00,4'b1101,0)));
    tbl.push_back(v(0, 6'b000000, 6'b000111, 0, 1, e_rwb));
    // sub, sll
    tbl.push_back(v(0, 6'b000000, 6'b100010, 0, 1, e_fgo));
    tbl.push_back(v(0, 6'b000000, 6'b100010, 0, 1, e_dec));
    tbl.push_back(v(0, 6'b000000, 6'b100010, 0, 1, o(0,2'b00,0,0,0,0,0,0,0,1,2'b00,4'b0110,0)));
    tbl.push_back(v(0, 6'b000000, 6'b100010, 0, 1, e_rwb));
    tbl.push_back(v(0, 6'b000000, 6'b000000, 0, 1, e_fgo));
    tbl.push_back(v(0, 6'b000000, 6'b000000, 0, 1, e_dec));
    tbl.push_back(v(0, 6'b000000, 6'b000000, 0, 1, o(0,2'b00,0,0,0,0,0,0,0,1,2'b00,4'b1000,0)));
    tbl.push_back(v(0, 6'b000000, 6'b000000, 0, 1, e_rwb));
    // ori, slti
    tbl.push_back(v(0, 6'b001101, 6'd0, 0, 1, e_fgo));
    tbl.push_back(v(0, 6'b001101, 6'd0, 0, 1, e_dec));
    tbl.push_back(v(0, 6'b001101, 6'd0, 0, 1, o(0,2'b00,0,0,0,0,0,0,0,1,2'b10,4'b0001,0)));
    tbl.push_back(v(0, 6'b001101, 6'd0, 0, 1, e_iwb));
    tbl.push_back(v(0, 6'b001010, 6'd0, 0, 1, e_fgo));
    tbl.push_back(v(0, 6'b001010, 6'd0, 0, 1, e_dec));
    tbl.push_back(v(0, 6'b001010, 6'd0, 0, 1, o(0,2'b00,0,0,0,0,0,0,0,1,2'b10,4'b0111,0)));
    tbl.push_back(v(0, 6'b001010, 6'd0, 0, 1, e_iwb));
    // beq zf=1 takes, bne zf=1 does not, bne zf=0 takes, beq zf=0 does not
    tbl.push_back(v(0, 6'b000100, 6'd0, 1, 1, e_fgo));
    tbl.push_back(v(0, 6'b000100, 6'd0, 1, 1, e_dec));
    tbl.push_back(v(0, 6'b000100, 6'd0, 1, 1, o(1,2'b01,0,0,0,0,0,0,0,1,2'b00,4'b0110,0)));
    tbl.push_back(v(0, 6'b000101, 6'd0, 1, 1, e_fgo));
    tbl.push_back(v(0, 6'b000101, 6'd0, 1, 1, e_dec));
    tbl.push_back(v(0, 6'b000101, 6'd0, 1, 1, o(0,2'b01,0,0,0,0,0,0,0,1,2'b00,4'b0110,0)));
    tbl.push_back(v(0, 6'b000101, 6'd0, 0, 1, e_fgo));
    tbl.push_back(v(0, 6'b000101, 6'd0, 0, 1, e_dec));
    tbl.push_back(v(0, 6'b000101, 6'd0, 0, 1, o(1,2'b01,0,0,0,0,0,0,0,1,2'b00,4'b0110,0)));
    tbl.push_back(v(0, 6'b000100, 6'd0, 0, 1, e_fgo));
    tbl.push_back(v(0, 6'b000100, 6'd0, 0, 1, e_dec));
    tbl.push_back(v(0, 6'b000100, 6'd0, 0, 1, o(0,2'b01,0,0,0,0,0,0,0,1,2'b00,4'b0110,0)));
    // jump
    tbl.push_back(v(0, 6'b000010, 6'd0, 0, 1, e_fgo));
    tbl.push_back(v(0, 6'b000010, 6'd0, 0, 1, e_dec));
    tbl.push_back(v(0, 6'b000010, 6'd0, 0, 1, e_jump));
    // illegal R-type funct: pulse in DECODE, back to FETCH (held by mem_ready=0)
    tbl.push_back(v(0, 6'b000000, 6'b111111, 0, 1, e_fgo));
    tbl.push_back(v(0, 6'b000000, 6'b111111, 0, 1, o(0,2'b00,0,0,0,0,0,0,0,0,2'b11,4'b0010,1)));
    tbl.push_back(v(0, 6'b000000, 6'b111111, 0, 0, e_fwait));
    tbl.push_back(v(0, 6'b000000, 6'b111111, 0, 0, e_fwait));

    rst = 1'b1; opcode = '0; funct = '0; zero_flag = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // sw with memory stalled 4 cycles: mem_write held 5 cycles total
    apply(v(0, 6'b101011, 6'd0, 0, 1, e_fgo), "sw_fetch");
    apply(v(0, 6'b101011, 6'd0, 0, 1, e_dec), "sw_decode");
    apply(v(0, 6'b101011, 6'd0, 0, 1, e_memadr), "sw_memadr");
    for (int k = 0; k < 4; k++)
      apply(v(0, 6'b101011, 6'd0, 0, 0, e_memwr), $sformatf("sw_wait%0d", k));
    apply(v(0, 6'b101011, 6'd0, 0, 1, e_memwr), "sw_done");
    apply(v(0, 6'b101011, 6'd0, 0, 0, e_fwait), "sw_to_fetch");

    // reset for 3 cycles while lw waits in MEMRD
    apply(v(0, 6'b100011, 6'd0, 0, 1, e_fgo), "lwr_fetch");
    apply(v(0, 6'b100011, 6'd0, 0, 1, e_dec), "lwr_decode");
    apply(v(0, 6'b100011, 6'd0, 0, 1, e_memadr), "lwr_memadr");
    apply(v(0, 6'b100011, 6'd0, 0, 0, e_memrd), "lwr_wait");
    apply(v(1, 6'b100011, 6'd0, 0, 0, o(0,2'b00,1,0,0,0,0,0,0,0,2'b00,4'b0010,0)), "lwr_rst0");
    apply(v(1, 6'b100011, 6'd0, 0, 0, e_rst), "lwr_rst1");
    apply(v(1, 6'b100011, 6'd0, 0, 0, e_rst), "lwr_rst2");
    apply(v(0, 6'b100011, 6'd0, 0, 0, e_fwait), "lwr_release");

    // opcode 111111: single-cycle pulse, then FETCH, no writes
    apply(v(0, 6'b111111, 6'd0, 0, 1, e_fgo), "ill_fetch");
    apply(v(0, 6'b111111, 6'd0, 0, 1, o(0,2'b00,0,0,0,0,0,0,0,0,2'b11,4'b0010,1)), "ill_decode");
    apply(v(0, 6'b111111, 6'd0, 0, 0, e_fwait), "ill_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instr[31:26], taken from the instruction register.
- funct  in  6  instr[5:0].
- zero_flag  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pc_en  out  1  PC register load enable.
- pc_src  out  2  PC source: 00 ALU result, 01 ALU-out register, 10 jump target.
- iord  out  1  memory address source: 0 PC, 1 ALU-out.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  write register: 0 rt, 1 rd.
- mem_to_reg  out  1  write-back data: 0 ALU-out, 1 memory data.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU operand A: 0 PC, 1 register A.
- alu_src_b  out  2  ALU operand B: 00 register B, 01 constant 4, 10 signimm, 11 signimm<<2.
- alu_control  out  ALU_CTRL_WIDTH  ALU operation code.
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode or funct.

Function
REQ-003 The FSM SHALL implement these states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, IMM_EX, IMM_WB, BRANCH, JUMP.
REQ-004 FETCH SHALL assert mem_read with iord=0, alu_src_a=0, alu_src_b=01 and alu_control=ADD.
- While mem_ready=0: stay in FETCH; assert no enables.
- When mem_ready=1: assert ir_write and pc_en (pc_src=00); go to DECODE.
REQ-005 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_control=ADD (branch target into ALU-out), then branch on opcode:
- 100011 or 101011 -> MEMADR.
- 000000 -> RTYPE_EX.
- 001000, 001100, 001101, 001110, 001010 -> IMM_EX.
- 000100, 000101 -> BRANCH.
- 000010 -> JUMP.
- any other opcode -> FETCH with illegal_instr=1.
REQ-006 An R-type instruction whose funct is not in REQ-011 SHALL be treated as illegal in DECODE: illegal_instr=1, next state FETCH.
REQ-007 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, ADD; next state MEMRD for lw, MEMWR for sw.
REQ-008 MEMRD and MEMWR SHALL hold iord=1 with mem_read or mem_write respectively until mem_ready=1.
- MEMRD then goes to MEMWB.
- MEMWR then goes to FETCH.
REQ-009 MEMWB SHALL assert reg_write with reg_dst=0 and mem_to_reg=1; next state FETCH.
REQ-010 RTYPE_EX SHALL drive alu_src_a=1, alu_src_b=00 and the funct-decoded alu_control.
- RTYPE_WB then asserts reg_write with reg_dst=1 and mem_to_reg=0.
REQ-011 Funct to alu_control mapping:
- add 100000 -> 0010; sub 100010 -> 0110; and 100100 -> 0000; or 100101 -> 0001.
- xor 100110 -> 0011; nor 100111 -> 0100; slt 101010 -> 0111.
- sll 000000 -> 1000; srl 000010 -> 1001; sra 000011 -> 1010.
- sllv 000100 -> 1011; srlv 000110 -> 1100; srav 000111 -> 1101.
REQ-012 IMM_EX SHALL drive alu_src_a=1, alu_src_b=10 with this mapping:
- addi -> 0010; andi -> 0000; ori -> 0001; xori -> 0011; slti -> 0111.
- IMM_WB then asserts reg_write with reg_dst=0 and mem_to_reg=0.
REQ-013 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, SUB and pc_src=01.
- pc_en = zero_flag for beq.
- pc_en = ~zero_flag for bne.
- Next state FETCH.
REQ-014 JUMP SHALL assert pc_en with pc_src=10; next state FETCH.
REQ-015 All outputs SHALL be combinational functions of the current state, latched opcode/funct, zero_flag and mem_ready.
- Every enable not named for a state SHALL be 0 in that state.
- Unlisted selects SHALL be 0; alu_control SHALL default to ADD.
REQ-016 Cycles per instruction with mem_ready tied high SHALL be:
- lw 5; sw 4; R-type 4; immediate 4; branch 3; jump 3.

Reset
REQ-017 With rst=1 at a clock edge, the state SHALL become FETCH, whatever the current state, including mid-wait in MEMRD or MEMWR.
REQ-018 During reset, all enables (pc_en, mem_read, mem_write, ir_write, reg_write) and illegal_instr SHALL be 0.
REQ-019 The first FETCH memory request SHALL occur in the first cycle after rst deasserts.

Structure
REQ-020 The state enum, the opcode and funct constants and the alu_control encodings SHALL live in mips_pkg, next to ALU_CTRL_WIDTH.
REQ-021 Funct/opcode-to-alu_control decoding SHALL be a sub-module named alu_decoder; the FSM SHALL be in multicycle_ctrl.

Verification
REQ-022 Reset held for 3 cycles during MEMRD with mem_ready=0 -> state FETCH; no write asserted; mem_read=1 in the first cycle after release.
REQ-023 lw (opcode 100011), mem_ready high -> 5 cycles; reg_write=1 only in cycle 5, with mem_to_reg=1.
REQ-024 R-type srav (funct 000111) -> alu_control=1101 in RTYPE_EX; reg_write with reg_dst=1 one cycle later.
REQ-025 beq with zero_flag=1, then bne with zero_flag=1 -> pc_en=1 in BRANCH for beq only.
REQ-026 sw with mem_ready low for 4 cycles -> mem_write held 5 cycles; return to FETCH after mem_ready rises.
REQ-027 opcode 111111 -> illegal_instr pulses for exactly 1 cycle in DECODE; next state FETCH; no reg_write or pc_en.
